result_bcd_converter: RTL

- Sequential binary-to-BCD converter using double-dabble (shift-and-add-3). One bit is processed per clock.
- Sits directly downstream of the calculator's divider. It takes the unsigned WIDTH-bit quotient and produces packed BCD digits, a leading-zero blank mask and an overflow flag for the display stage.
- Uses a valid/ready handshake on both sides. It holds one conversion at a time.

---
 rtl/result_bcd_converter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Produces packed BCD digits, a leading-zero blank mask and an overflow flag.
module result_bcd_converter #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    sr_q, sr_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                ovf_q, ovf_d;
    logic                out_valid_q, out_valid_d;

    logic [ACC_W-1:0]    acc_adj;
    logic [DIGITS-1:0]   blank_c;
    logic                all_zero;

    // Add-3 correction on every digit >= 5, all digits evaluated in parallel
    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Digit k is blank when it and every higher digit are zero; units never blank
    always_comb begin
        blank_c  = '0;
        all_zero = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            all_zero   = all_zero & (acc_q[4*k +: 4] == 4'd0);
            blank_c[k] = all_zero;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sr_d    = in_data;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    // Carry out of the top digit is the only overflow source
                    {acc_d, sr_d} = {acc_adj[ACC_W-2:0], sr_q, 1'b0};
                    ovf_d         = ovf_q | acc_adj[ACC_W-1];
                    cnt_d         = cnt_q - CNT_W'(1);
                end else begin
                    bcd_d       = acc_q;
                    blank_d     = blank_c;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            blank_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign bcd       = bcd_q;
    assign blank     = blank_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule
